std_store_buffer: RTL and testbench

STD_STORE_BUFFER -- requirements
Module: std_store_buffer

---
 rtl/std_cache_pkg.sv | 20 ++
 rtl/sbuf_fifo.sv | 57 +++++
 rtl/std_store_buffer.sv | 133 +++++++++++++
 tb/tb_std_store_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared store-buffer entry type and issue FSM states
package std_cache_pkg;

  // Entries carry a fixed-width paddr; instances with PLEN < 64 zero-extend into it.
  localparam int SBUF_PADDR_W = 64;

  typedef struct packed {
    logic [SBUF_PADDR_W-1:0] paddr;
    logic [63:0]             data;
    logic [7:0]              be;
    logic [1:0]              size;
  } sbuf_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_TAG  = 2'd2
  } sbuf_state_e;

endpackage

// File: rtl/sbuf_fifo.sv
// rtl/sbuf_fifo.sv - circular store FIFO with wrapping pointers and occupancy count
module sbuf_fifo
  import std_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   push_i,
  input  logic                                   pop_i,
  input  sbuf_entry_t                            wdata_i,
  output sbuf_entry_t                            head_o,
  output logic [$clog2(DEPTH)-1:0]               rptr_o,
  output logic [$clog2(DEPTH):0]                 count_o,
  output logic [DEPTH-1:0][SBUF_PADDR_W-1:0]     paddr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so plain pointer overflow gives the DEPTH-1 -> 0 wrap.
  always_comb begin
    wptr_d  = wptr_q + PW'(push_i);
    rptr_d  = rptr_q + PW'(pop_i);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) paddr_o[i] = mem_q[i].paddr;
  end

  assign head_o  = mem_q[rptr_q];
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

// File: rtl/std_store_buffer.sv
// rtl/std_store_buffer.sv - store buffer issuing buffered stores to a cache port (IDLE/REQ/TAG)
// Load page-offset hazard check is compiled in only with STD_SBUF_OFFSET_CHECK_EN.
module std_store_buffer
  import std_cache_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PLEN    = 56,
  parameter int INDEX_W = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [PLEN-1:0]         st_paddr_i,
  input  logic [63:0]             st_data_i,
  input  logic [7:0]              st_be_i,
  input  logic [1:0]              st_size_i,
  input  logic                    flush_i,
  output logic                    empty_o,
  input  logic                    stall_i,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic                    we_o,
  output logic [INDEX_W-1:0]      index_o,
  output logic [PLEN-INDEX_W-1:0] tag_o,
  output logic                    tag_valid_o,
  output logic [63:0]             data_o,
  output logic [7:0]              be_o,
  output logic [1:0]              size_o,
  input  logic [INDEX_W-1:0]      ld_offset_i,
  output logic                    offset_match_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sbuf_state_e                          state_q, state_d;
  logic [PLEN-INDEX_W-1:0]              tag_q, tag_d;
  logic                                 push, pop;
  sbuf_entry_t                          wentry, head;
  logic [PW-1:0]                        rptr;
  logic [CW-1:0]                        count;
  logic [DEPTH-1:0][SBUF_PADDR_W-1:0]   paddr_all;
  logic                                 unused_bits;

  assign st_ready_o = (count != CW'(DEPTH)) && !flush_i;
  assign push       = st_valid_i && st_ready_o;
  assign pop        = (state_q == SB_REQ) && gnt_i;

  always_comb begin
    wentry.paddr = SBUF_PADDR_W'(st_paddr_i);
    wentry.data  = st_data_i;
    wentry.be    = st_be_i;
    wentry.size  = st_size_i;
  end

  sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .head_o  (head),
    .rptr_o  (rptr),
    .count_o (count),
    .paddr_o (paddr_all)
  );

  // Stall only gates leaving IDLE; a raised request is held until granted.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    case (state_q)
      SB_IDLE: if (count != '0 && !stall_i) state_d = SB_REQ;
      SB_REQ: begin
        if (gnt_i) begin
          state_d = SB_TAG;
          tag_d   = head.paddr[PLEN-1:INDEX_W];
        end
      end
      SB_TAG:  state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SB_IDLE;
    else       state_q <= state_d;
    tag_q <= tag_d;
  end

  assign req_o       = (state_q == SB_REQ);
  assign tag_valid_o = (state_q == SB_TAG);
  assign we_o        = 1'b1;
  assign index_o     = head.paddr[INDEX_W-1:0];
  assign tag_o       = tag_q;
  assign data_o      = head.data;
  assign be_o        = head.be;
  assign size_o      = head.size;
  assign empty_o     = (count == '0) && (state_q == SB_IDLE);

`ifdef STD_SBUF_OFFSET_CHECK_EN
  localparam int OW = INDEX_W - 3;

  logic [OW-1:0]    toff_q, toff_d;
  logic [PW-1:0]    rel [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             match;

  // Compare at doubleword granularity; the popped store stays visible through its tag phase.
  always_comb begin
    toff_d = toff_q;
    if (pop) toff_d = head.paddr[INDEX_W-1:3];
    match = (state_q == SB_TAG) && (toff_q == ld_offset_i[INDEX_W-1:3]);
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]   = PW'(i) - rptr;
      valid[i] = CW'(rel[i]) < count;
      if (valid[i] && (paddr_all[i][INDEX_W-1:3] == ld_offset_i[INDEX_W-1:3])) match = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    toff_q <= toff_d;
  end

  assign offset_match_o = match;
`else
  assign offset_match_o = 1'b0;
`endif

  assign unused_bits = ^{paddr_all, head.paddr, ld_offset_i, rptr};

endmodule

// File: tb/tb_std_store_buffer.sv
// tb/tb_std_store_buffer.sv - directed and randomized bench for std_store_buffer against a queue model
module tb_std_store_buffer;

  localparam int DEPTH   = 4;
  localparam int PLEN    = 56;
  localparam int INDEX_W = 12;

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    st_valid_i = 1'b0;
  logic                    st_ready_o;
  logic [PLEN-1:0]         st_paddr_i = '0;
  logic [63:0]             st_data_i = '0;
  logic [7:0]              st_be_i = '0;
  logic [1:0]              st_size_i = '0;
  logic                    flush_i = 1'b0;
  logic                    empty_o;
  logic                    stall_i = 1'b0;
  logic                    req_o;
  logic                    gnt_i = 1'b0;
  logic                    we_o;
  logic [INDEX_W-1:0]      index_o;
  logic [PLEN-INDEX_W-1:0] tag_o;
  logic                    tag_valid_o;
  logic [63:0]             data_o;
  logic [7:0]              be_o;
  logic [1:0]              size_o;
  logic [INDEX_W-1:0]      ld_offset_i = '0;
  logic                    offset_match_o;

  always #5 clk = ~clk;

  std_store_buffer #(.DEPTH(DEPTH), .PLEN(PLEN), .INDEX_W(INDEX_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .st_valid_i     (st_valid_i),
    .st_ready_o     (st_ready_o),
    .st_paddr_i     (st_paddr_i),
    .st_data_i      (st_data_i),
    .st_be_i        (st_be_i),
    .st_size_i      (st_size_i),
    .flush_i        (flush_i),
    .empty_o        (empty_o),
    .stall_i        (stall_i),
    .req_o          (req_o),
    .gnt_i          (gnt_i),
    .we_o           (we_o),
    .index_o        (index_o),
    .tag_o          (tag_o),
    .tag_valid_o    (tag_valid_o),
    .data_o         (data_o),
    .be_o           (be_o),
    .size_o         (size_o),
    .ld_offset_i    (ld_offset_i),
    .offset_match_o (offset_match_o)
  );

  typedef struct {
    logic [PLEN-1:0] paddr;
    logic [63:0]     data;
    logic [7:0]      be;
    logic [1:0]      size;
  } m_ent_t;

  // Reference: a queue of buffered stores plus the issue phase (0 idle, 1 requesting, 2 tag).
  m_ent_t          m_q[$];
  int              m_phase = 0;
  logic [PLEN-1:0] m_tag = '0;
  int              checks = 0;
  int              failures = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic exp_match();
    logic r;
    r = 1'b0;
`ifdef STD_SBUF_OFFSET_CHECK_EN
    foreach (m_q[i]) if (m_q[i].paddr[11:3] == ld_offset_i[11:3]) r = 1'b1;
    if (m_phase == 2 && m_tag[11:3] == ld_offset_i[11:3]) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic check_model();
    chk("st_ready", st_ready_o, (m_q.size() != DEPTH) && !flush_i);
    chk("empty", empty_o, (m_q.size() == 0) && (m_phase == 0));
    chk("req", req_o, m_phase == 1);
    chk("tag_valid", tag_valid_o, m_phase == 2);
    chk("we", we_o, 1'b1);
    if (m_phase == 1) begin
      chk("index", index_o, m_q[0].paddr[INDEX_W-1:0]);
      chk("data", data_o, m_q[0].data);
      chk("be", be_o, m_q[0].be);
      chk("size", size_o, m_q[0].size);
    end
    if (m_phase == 2) chk("tag", tag_o, m_tag[PLEN-1:INDEX_W]);
    chk("offset_match", offset_match_o, exp_match());
  endtask

  task automatic tick();
    bit     push;
    m_ent_t e;
    push = st_valid_i && (m_q.size() != DEPTH) && !flush_i;
    e.paddr = st_paddr_i; e.data = st_data_i; e.be = st_be_i; e.size = st_size_i;
    if (rst_i) begin
      m_q.delete();
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (m_q.size() != 0 && !stall_i) m_phase = 1;
        1: if (gnt_i) begin m_tag = m_q[0].paddr; void'(m_q.pop_front()); m_phase = 2; end
        default: m_phase = 0;
      endcase
      if (push) m_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_store(input logic [PLEN-1:0] pa, input logic [63:0] d,
                           input logic [7:0] be, input logic [1:0] sz);
    st_valid_i = 1'b1; st_paddr_i = pa; st_data_i = d; st_be_i = be; st_size_i = sz;
  endtask

  task automatic drain(input string name);
    st_valid_i = 1'b0; stall_i = 1'b0; gnt_i = 1'b1;
    for (int i = 0; i < 40 && !empty_o; i++) tick();
    chk(name, empty_o, 1'b1);
  endtask

  initial begin
    logic [63:0]        r64;
    logic [INDEX_W-1:0] saved_idx;
    logic [63:0]        tags [$];
    int                 tcyc [$];

    // Reset state
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_ready", st_ready_o, 1'b1);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_req", req_o, 1'b0);
    chk("rst_tag_valid", tag_valid_o, 1'b0);
    chk("rst_match", offset_match_o, 1'b0);

    // Single store with grant held: req, tag, empty on successive cycles
    gnt_i = 1'b1;
    set_store(56'h8000_1008, 64'hDEAD_BEEF, 8'h0F, 2'd2);
    tick();
    st_valid_i = 1'b0;
    chk("t23_c0_req", req_o, 1'b0);
    tick();
    chk("t23_c1_req", req_o, 1'b1);
    chk("t23_c1_index", index_o, 12'h008);
    chk("t23_c1_data", data_o, 64'hDEAD_BEEF);
    tick();
    chk("t23_c2_tag_valid", tag_valid_o, 1'b1);
    chk("t23_c2_tag", tag_o, 64'h80001);
    tick();
    chk("t23_c3_empty", empty_o, 1'b1);
    chk("t23_c3_tag_valid", tag_valid_o, 1'b0);

    // Fill to DEPTH with no grant, then a refused push alongside a pop
    gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(56'h10_0000 + 56'(i * 8), 64'h100 + 64'(i), 8'hFF, 2'd3);
      tick();
    end
    chk("t24_full_ready", st_ready_o, 1'b0);
    set_store(56'h99_9000, 64'h5555, 8'h01, 2'd0);
    gnt_i = 1'b1;
    tick();
    st_valid_i = 1'b0;
    chk("t24_after_pop_ready", st_ready_o, 1'b1);
    chk("t24_tag_phase", tag_valid_o, 1'b1);
    drain("t24_drain");

    // Stall blocks issue; on release two stores issue in order, three cycles apart
    stall_i = 1'b1; gnt_i = 1'b1;
    set_store(56'hA_B000, 64'h1, 8'h03, 2'd1); tick();
    set_store(56'hC_D000, 64'h2, 8'h0C, 2'd1); tick();
    st_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t25_stalled_req", req_o, 1'b0);
    end
    stall_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (tag_valid_o) begin tags.push_back(64'(tag_o)); tcyc.push_back(c); end
    end
    chk("t25_issued", tags.size(), 2);
    if (tags.size() == 2) begin
      chk("t25_first_tag", tags[0], 64'hAB);
      chk("t25_second_tag", tags[1], 64'hCD);
      chk("t25_spacing", tcyc[1] - tcyc[0], 3);
    end

    // Stall raised while requesting does not drop the request
    stall_i = 1'b0; gnt_i = 1'b0;
    set_store(56'h77_7ABC, 64'h77, 8'h80, 2'd0); tick();
    st_valid_i = 1'b0;
    tick();
    chk("t26_req_up", req_o, 1'b1);
    saved_idx = index_o;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t26_req_held", req_o, 1'b1);
      chk("t26_index_held", index_o, saved_idx);
    end
    gnt_i = 1'b1;
    tick();
    chk("t26_tag_after_gnt", tag_valid_o, 1'b1);
    drain("t26_drain");

    // Page-offset hazard check at doubleword granularity
    stall_i = 1'b1; gnt_i = 1'b0;
    set_store(56'h0000_0238, 64'h238, 8'hFF, 2'd3); tick();
    st_valid_i = 1'b0;
    ld_offset_i = 12'h23C; #1;
`ifdef STD_SBUF_OFFSET_CHECK_EN
    chk("t27_match_same_dw", offset_match_o, 1'b1);
`else
    chk("t27_match_disabled", offset_match_o, 1'b0);
`endif
    ld_offset_i = 12'h240; #1;
    chk("t27_match_next_dw", offset_match_o, 1'b0);
    drain("t27_drain");

    // Reset during the tag phase with three entries still buffered
    stall_i = 1'b0; gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(56'h20_0000 + 56'(i * 8), 64'h200 + 64'(i), 8'hF0, 2'd2);
      tick();
    end
    st_valid_i = 1'b0; gnt_i = 1'b1;
    tick();
    chk("t28_in_tag", tag_valid_o, 1'b1);
    rst_i = 1'b1; gnt_i = 1'b0;
    tick();
    chk("t28_tag_valid", tag_valid_o, 1'b0);
    chk("t28_empty", empty_o, 1'b1);
    chk("t28_ready", st_ready_o, 1'b1);
    rst_i = 1'b0;
    tick();
    chk("t28_no_late_tag", tag_valid_o, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom(), $urandom()};
      st_valid_i  = ($urandom_range(0, 1) == 1);
      st_paddr_i  = r64[PLEN-1:0];
      st_paddr_i[11:3] = 9'($urandom_range(0, 15));
      st_data_i   = {$urandom(), $urandom()};
      st_be_i     = 8'($urandom_range(0, 255));
      st_size_i   = 2'($urandom_range(0, 3));
      gnt_i       = ($urandom_range(0, 3) != 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 15) == 0);
      ld_offset_i = 12'($urandom_range(0, 15) << 3) | 12'($urandom_range(0, 7));
      tick();
    end

    // Flush drains what remains and refuses new stores
    flush_i = 1'b1;
    set_store(56'h55_5000, 64'h55, 8'hFF, 2'd3);
    #1;
    chk("flush_ready", st_ready_o, 1'b0);
    stall_i = 1'b0; gnt_i = 1'b1;
    for (int i = 0; i < 40 && !empty_o; i++) tick();
    chk("flush_drain", empty_o, 1'b1);
    tick();
    chk("flush_stays_empty", empty_o, 1'b1);
    flush_i = 1'b0; st_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
